// File: rtl/pic_irq_ctrl_param.sv
// Parametrised 8259A-style interrupt controller: synchronised request lines, masking,
// edge/level trigger, fixed/rotating fully nested priority and a two-pulse INTA handshake.
module pic_irq_ctrl_param #(
  parameter int unsigned N_IRQ       = 16,
  parameter int unsigned ID_W        = 5,
  parameter int unsigned VEC_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] ir,
  input  logic             inta_n,
  input  logic             wr_en,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             int_o,
  output logic [VEC_W-1:0] vec_out,
  output logic             vec_valid
);

  localparam int unsigned CTRL_W = 3;

  typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

  state_t             state_q, state_d;
  logic [N_IRQ-1:0]   ir_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] inta_sync;
  logic [N_IRQ-1:0]   ir_s, ir_q, rise;
  logic               inta_s, inta_q, ack_edge;

  logic [CTRL_W-1:0]  ctrl;
  logic [VEC_W-1:0]   base;
  logic [N_IRQ-1:0]   imr, irr, isr, irr_d, isr_d;
  logic [N_IRQ-1:0]   irr_clr, isr_set, isr_clr;
  logic [ID_W-1:0]    ptr, ptr_d, p_eff;
  logic               level, aeoi, rotate;

  int                 isr_rank;
  logic [ID_W-1:0]    isr_top, win_id;
  logic               win_found;

  logic               eoi_hit, aeoi_hit;
  logic [ID_W-1:0]    eoi_k, eoi_id;

  logic [ID_W-1:0]    lat_id, lat_d;
  logic               spur, spur_d;
  logic [VEC_W-1:0]   vec_out_d;
  logic               vec_valid_d, int_o_d;
  logic               unused_wdata;

  assign level  = ctrl[0];
  assign aeoi   = ctrl[1];
  assign rotate = ctrl[2];
  assign p_eff  = rotate ? ptr : '0;
  assign unused_wdata = ^wdata;

  // Id at priority rank i when rank 0 is id p.
  function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= int'(N_IRQ)) s = s - int'(N_IRQ);
    return ID_W'(s);
  endfunction

  // Input synchronisers and edge detectors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) ir_sync[s] <= '0;
      inta_sync <= '1;
      ir_q      <= '0;
      inta_q    <= 1'b1;
    end else begin
      ir_sync[0] <= ir;
      for (int s = 1; s < int'(SYNC_STAGES); s++) ir_sync[s] <= ir_sync[s-1];
      inta_sync <= {inta_sync[SYNC_STAGES-2:0], inta_n};
      ir_q      <= ir_s;
      inta_q    <= inta_s;
    end
  end

  assign ir_s     = ir_sync[SYNC_STAGES-1];
  assign inta_s   = inta_sync[SYNC_STAGES-1];
  assign rise     = ir_s & ~ir_q;
  assign ack_edge = inta_q & ~inta_s;

  // Highest in-service rank and the best eligible request strictly above it
  always_comb begin
    isr_rank  = int'(N_IRQ);
    isr_top   = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (isr[rot_idx(p_eff, i)]) begin
        isr_rank = i;
        isr_top  = rot_idx(p_eff, i);
      end
    end
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (irr[rot_idx(p_eff, i)] && !imr[rot_idx(p_eff, i)] && (i < isr_rank)) begin
        win_found = 1'b1;
        win_id    = rot_idx(p_eff, i);
      end
    end
  end

  // EOI command decode
  assign eoi_id = wdata[ID_W-1:0];

  always_comb begin
    eoi_hit = 1'b0;
    eoi_k   = '0;
    if (wr_en && (addr == 2'd3)) begin
      if (wdata[8]) begin
        if (isr_rank < int'(N_IRQ)) begin
          eoi_hit = 1'b1;
          eoi_k   = isr_top;
        end
      end else if ((32'(eoi_id) < N_IRQ) && isr[eoi_id]) begin
        eoi_hit = 1'b1;
        eoi_k   = eoi_id;
      end
    end
  end

  // Acknowledge FSM: next state and registered-output next values
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_id;
    spur_d      = spur;
    vec_out_d   = vec_out;
    vec_valid_d = 1'b0;
    int_o_d     = 1'b0;
    isr_set     = '0;
    irr_clr     = '0;
    aeoi_hit    = 1'b0;
    case (state_q)
      IDLE: begin
        int_o_d = win_found;
        if (ack_edge) begin
          state_d = ACK1;
          int_o_d = 1'b0;
          if (win_found) begin
            lat_d           = win_id;
            spur_d          = 1'b0;
            isr_set[win_id] = 1'b1;
            if (!level) irr_clr[win_id] = 1'b1;
          end else begin
            lat_d  = ID_W'(N_IRQ - 1);
            spur_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (ack_edge) begin
          state_d     = ACK2;
          vec_valid_d = 1'b1;
          vec_out_d   = base + VEC_W'(lat_id);
          if (aeoi && !spur && isr[lat_id]) aeoi_hit = 1'b1;
        end
      end
      ACK2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_id    <= '0;
      spur      <= 1'b0;
      vec_out   <= '0;
      vec_valid <= 1'b0;
      int_o     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_id    <= lat_d;
      spur      <= spur_d;
      vec_out   <= vec_out_d;
      vec_valid <= vec_valid_d;
      int_o     <= int_o_d;
    end
  end

  // Request/in-service next values; an ack-time set beats a same-cycle EOI
  always_comb begin
    isr_clr = '0;
    if (eoi_hit)  isr_clr[eoi_k]  = 1'b1;
    if (aeoi_hit) isr_clr[lat_id] = 1'b1;
    isr_d = (isr & ~isr_clr) | isr_set;
    irr_d = level ? ir_s : ((irr & ~irr_clr) | rise);
    ptr_d = ptr;
    if (rotate) begin
      if (aeoi_hit) ptr_d = rot_idx(lat_id, 1);
      if (eoi_hit && !isr_set[eoi_k]) ptr_d = rot_idx(eoi_k, 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
      base <= '0;
      imr  <= '1;
      irr  <= '0;
      isr  <= '0;
      ptr  <= '0;
    end else begin
      if (wr_en) begin
        case (addr)
          2'd0:    ctrl <= wdata[CTRL_W-1:0];
          2'd1:    base <= wdata[VEC_W-1:0];
          2'd2:    imr  <= wdata[N_IRQ-1:0];
          default: ;
        endcase
      end
      irr <= irr_d;
      isr <= isr_d;
      ptr <= ptr_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata = 32'(irr);
      2'd1:    rdata = 32'(isr);
      2'd2:    rdata = 32'(imr);
      default: rdata = 32'({ctrl, base});
    endcase
  end

endmodule

// File: tb/tb_pic_irq_ctrl_param.sv
// Randomised bench for pic_irq_ctrl_param against a transaction-level priority model.
module tb_pic_irq_ctrl_param;
  localparam int N   = 16;
  localparam int IDW = 5;
  localparam int VW  = 8;
  localparam int SS  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  ir;
  logic          inta_n;
  logic          wr_en;
  logic [1:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          int_o;
  logic [VW-1:0] vec_out;
  logic          vec_valid;

  pic_irq_ctrl_param #(.N_IRQ(N), .ID_W(IDW), .VEC_W(VW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .inta_n(inta_n), .wr_en(wr_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .int_o(int_o), .vec_out(vec_out), .vec_valid(vec_valid)
  );

  always #5 clk = ~clk;

  logic [2:0]    m_ctrl;
  logic [VW-1:0] m_base;
  logic [N-1:0]  m_imr, m_irr, m_isr, m_ir;
  int            m_ptr, m_lat;
  bit            m_spur;
  int            n_chk = 0;
  int            n_fail = 0;
  int            mon_cnt = 0;
  logic [VW-1:0] mon_vec = '0;

  always @(posedge clk) begin
    if (rst_n && vec_valid) begin
      mon_cnt <= mon_cnt + 1;
      mon_vec <= vec_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: rank of id k when id p is highest priority
  function automatic int rank(input int k, input int p);
    return (k >= p) ? k - p : k + N - p;
  endfunction

  function automatic int top(input logic [N-1:0] m, input int p);
    int best;
    best = -1;
    for (int k = 0; k < N; k++)
      if (m[k] && (best < 0 || rank(k, p) < rank(best, p))) best = k;
    return best;
  endfunction

  function automatic int peff();
    return m_ctrl[2] ? m_ptr : 0;
  endfunction

  function automatic int winner();
    int t;
    logic [N-1:0] e;
    t = top(m_isr, peff());
    e = '0;
    for (int k = 0; k < N; k++)
      if (m_irr[k] && !m_imr[k] && (t < 0 || rank(k, peff()) < rank(t, peff()))) e[k] = 1'b1;
    return top(e, peff());
  endfunction

  task automatic m_clear(input int k);
    if (m_isr[k]) begin
      m_isr[k] = 1'b0;
      if (m_ctrl[2]) m_ptr = (k + 1) % N;
    end
  endtask

  task automatic m_reset();
    m_ctrl = '0; m_base = '0; m_imr = '1; m_irr = '0; m_isr = '0; m_ir = '0; m_ptr = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1 d = rdata;
  endtask

  task automatic do_reset();
    ir = '0; inta_n = 1'b1; wr_en = 1'b0; addr = '0; wdata = '0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    m_reset();
  endtask

  task automatic op_ir(input logic [N-1:0] v);
    ir = v;
    if (m_ctrl[0]) m_irr = v;
    else m_irr = m_irr | (v & ~m_ir);
    m_ir = v;
    cyc(6);
  endtask

  task automatic op_wr(input logic [1:0] a, input logic [31:0] d);
    int t;
    addr = a; wdata = d; wr_en = 1'b1;
    cyc(1);
    wr_en = 1'b0;
    case (a)
      2'd0: begin
        m_ctrl = d[2:0];
        if (d[0]) m_irr = m_ir;
      end
      2'd1: m_base = d[VW-1:0];
      2'd2: m_imr = d[N-1:0];
      default: begin
        if (d[8]) begin
          t = top(m_isr, peff());
          if (t >= 0) m_clear(t);
        end else if (int'(d[IDW-1:0]) < N) m_clear(int'(d[IDW-1:0]));
      end
    endcase
    cyc(3);
  endtask

  task automatic op_ack();
    int w, c0;
    logic [VW-1:0] ev;
    c0 = mon_cnt;
    w = winner();
    if (w >= 0) begin
      m_isr[w] = 1'b1;
      if (!m_ctrl[0]) m_irr[w] = 1'b0;
      m_lat = w; m_spur = 1'b0;
    end else begin
      m_lat = N - 1; m_spur = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      inta_n = 1'b0; cyc(5);
      inta_n = 1'b1; cyc(5);
    end
    ev = VW'(int'(m_base) + m_lat);
    if (m_ctrl[1] && !m_spur) m_clear(m_lat);
    check("vec_cnt", 32'(mon_cnt - c0), 32'd1);
    check("vec_out", 32'(mon_vec), 32'(ev));
    cyc(2);
  endtask

  task automatic chk_state();
    logic [31:0] d;
    reg_rd(2'd0, d); check("irr", d, 32'(m_irr));
    reg_rd(2'd1, d); check("isr", d, 32'(m_isr));
    reg_rd(2'd2, d); check("imr", d, 32'(m_imr));
    reg_rd(2'd3, d); check("cfg", d, 32'({m_ctrl, m_base}));
    check("int_o", 32'(int_o), 32'(winner() >= 0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [N-1:0] rv;
    do_reset();
    check("rst_int_o", 32'(int_o), 32'd0);
    check("rst_vec_out", 32'(vec_out), 32'd0);
    check("rst_vec_valid", 32'(vec_valid), 32'd0);
    chk_state();

    // Masked request is recorded but not raised
    op_ir(16'h0008); op_ir(16'h0000);
    reg_rd(2'd0, d); check("t1_irr", d, 32'h0008);
    check("t1_int_lo", 32'(int_o), 32'd0);
    op_wr(2'd2, 32'hFFF7);
    check("t1_int_hi", 32'(int_o), 32'd1);
    chk_state();

    // Basic acknowledge and non-specific EOI
    do_reset();
    op_wr(2'd1, 32'h20); op_wr(2'd2, 32'h0);
    op_ir(16'h0020); op_ir(16'h0000);
    op_ack();
    check("t2_vec", 32'(mon_vec), 32'h25);
    reg_rd(2'd1, d); check("t2_isr", d, 32'h0020);
    reg_rd(2'd0, d); check("t2_irr", d, 32'h0000);
    op_wr(2'd3, 32'h100);
    reg_rd(2'd1, d); check("t2_isr_eoi", d, 32'h0000);

    // Nesting
    op_ir(16'h0010); op_ir(16'h0000); op_ack();
    op_ir(16'h0040); op_ir(16'h0000);
    check("t3_int_lo", 32'(int_o), 32'd0);
    op_ir(16'h0004); op_ir(16'h0000);
    check("t3_int_hi", 32'(int_o), 32'd1);
    op_ack();
    check("t3_vec", 32'(mon_vec), 32'h22);
    reg_rd(2'd1, d); check("t3_isr", d, 32'h0014);
    chk_state();

    // Rotating priority
    do_reset();
    op_wr(2'd1, 32'h20); op_wr(2'd2, 32'h0); op_wr(2'd0, 32'h4);
    op_ir(16'h0003); op_ir(16'h0000);
    op_ack(); check("t4_vec0", 32'(mon_vec), 32'h20);
    op_wr(2'd3, 32'h100);
    op_ack(); check("t4_vec1", 32'(mon_vec), 32'h21);
    op_wr(2'd3, 32'h100);
    op_ir(16'h0005); op_ir(16'h0000);
    op_ack(); check("t4_vec2", 32'(mon_vec), 32'h22);
    chk_state();

    // Auto-EOI in level mode, then spurious ack
    do_reset();
    op_wr(2'd1, 32'h20); op_wr(2'd2, 32'h0); op_wr(2'd0, 32'h3);
    op_ir(16'h0080);
    op_ack(); check("t5_vec", 32'(mon_vec), 32'h27);
    reg_rd(2'd1, d); check("t5_isr", d, 32'h0000);
    check("t5_int_o", 32'(int_o), 32'd1);
    op_ir(16'h0000);
    op_ack(); check("t6_spur_vec", 32'(mon_vec), 32'h2F);
    reg_rd(2'd1, d); check("t6_isr", d, 32'h0000);

    // Reset in the middle of the handshake
    op_ir(16'h0080);
    inta_n = 1'b0; cyc(5); inta_n = 1'b1; cyc(3);
    ir = '0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_int_o", 32'(int_o), 32'd0);
    check("t6_rst_vec_out", 32'(vec_out), 32'd0);
    check("t6_rst_vec_valid", 32'(vec_valid), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    m_reset();
    cyc(2);
    chk_state();
    op_wr(2'd2, 32'h0);
    op_ir(16'h0200); op_ir(16'h0000);
    op_ack(); check("t6_new_ack", 32'(mon_vec), 32'h09);
    chk_state();

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 7))
        0, 1: begin rv = N'($urandom & $urandom); op_ir(rv); end
        2: op_wr(2'd0, 32'($urandom_range(0, 7)));
        3: op_wr(2'd2, $urandom & $urandom & $urandom);
        4: op_wr(2'd1, $urandom);
        5, 6: op_ack();
        default: begin
          if ($urandom_range(0, 1) == 1) op_wr(2'd3, 32'h100);
          else op_wr(2'd3, 32'($urandom_range(0, 31)));
        end
      endcase
      chk_state();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
